// File: rtl/csi_ctrl_pkg.sv
// Shared constants for the CSI-2 capture controller and its helpers.
package csi_ctrl_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned ERR_W       = 2;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FRAME_CNT_W = 16;

  // Capture FSM encoding
  localparam logic [STATE_W-1:0] S_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] S_ARM     = 2'd1;
  localparam logic [STATE_W-1:0] S_CAPTURE = 2'd2;
  localparam logic [STATE_W-1:0] S_FLUSH   = 2'd3;

  // Error codes reported on err_code
  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [ERR_W-1:0] ERR_LINE    = 2'd2;
  localparam logic [ERR_W-1:0] ERR_FRAME   = 2'd3;

  // Bits needed to hold values 0..max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/csi_wdt.sv
// Saturating stall watchdog: counts while enabled, fires at TIMEOUT-1.
module csi_wdt
  import csi_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic fire_c_o
);

  localparam int unsigned      CNT_W   = cnt_width(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on activity or when disabled, otherwise saturate
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fire_c_o = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/csi_capture_ctrl.sv
// Frame-capture sequencer between the CSI-2 packet handler and the pixel path.
module csi_capture_ctrl
  import csi_ctrl_pkg::*;
#(
  parameter int unsigned H_WORDS    = 640,
  parameter int unsigned V_LINES    = 480,
  parameter int unsigned TIMEOUT    = 1_000_000,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic                   single_shot,
  input  logic [DATA_W-1:0]      ph_data,
  input  logic                   ph_valid,
  input  logic                   ph_vsync,
  input  logic                   ph_done,
  output logic                   ph_rst_n,
  output logic [DATA_W-1:0]      pix_data,
  output logic                   pix_valid,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [ERR_W-1:0]       err_code,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned WORD_W = cnt_width(H_WORDS - 1);
  localparam int unsigned LINE_W = cnt_width(V_LINES);
  localparam int unsigned RST_W  = cnt_width(RST_CYCLES);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(H_WORDS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_LINES - 1);
  localparam logic [RST_W-1:0]  RST_END   = RST_W'(RST_CYCLES);

  logic [STATE_W-1:0]     state_q,     state_d;
  logic [WORD_W-1:0]      word_cnt_q,  word_cnt_d;
  logic [LINE_W-1:0]      line_cnt_q,  line_cnt_d;
  logic                   in_line_q,   in_line_d;
  logic                   wrapped_q,   wrapped_d;
  logic                   sof_seen_q,  sof_seen_d;
  logic                   single_q,    single_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [ERR_W-1:0]       err_code_q,  err_code_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [RST_W-1:0]       rst_cnt_q,   rst_cnt_d;
  logic [DATA_W-1:0]      pix_data_q,  pix_data_d;
  logic                   pix_valid_q, pix_valid_d;
  logic                   pix_sof_q,   pix_sof_d;
  logic                   pix_eol_q,   pix_eol_d;
  logic                   done_q,      done_d;
  logic                   err_q,       err_d;
  logic                   ph_rst_n_q,  ph_rst_n_d;
  logic                   busy_q,      busy_d;

  logic line_err;
  logic frame_last;
  logic wdt_clr;
  logic wdt_en;
  logic wdt_fire_c;

  assign wdt_en  = (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign wdt_clr = ph_valid || ph_vsync || ph_done || (state_d != state_q);

  csi_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .clr_i    (wdt_clr),
    .en_i     (wdt_en),
    .fire_c_o (wdt_fire_c)
  );

  // Next-state, counter and output decode
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    line_cnt_d  = line_cnt_q;
    in_line_d   = in_line_q;
    wrapped_d   = wrapped_q;
    sof_seen_d  = sof_seen_q;
    single_d    = single_q;
    stop_pend_d = stop_pend_q;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    rst_cnt_d   = '0;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    pix_sof_d   = 1'b0;
    pix_eol_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ph_rst_n_d  = 1'b1;
    line_err    = 1'b0;
    frame_last  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_start && !cmd_stop) begin
          state_d     = S_ARM;
          single_d    = single_shot;
          err_code_d  = ERR_NONE;
          stop_pend_d = 1'b0;
        end
      end

      S_ARM: begin
        if (wdt_fire_c) begin
          state_d    = S_FLUSH;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (ph_vsync) begin
          state_d    = S_CAPTURE;
          word_cnt_d = '0;
          line_cnt_d = '0;
          in_line_d  = 1'b0;
          wrapped_d  = 1'b0;
          sof_seen_d = 1'b0;
        end
      end

      S_CAPTURE: begin
        if (cmd_stop) begin
          stop_pend_d = 1'b1;
        end
        if (wdt_fire_c) begin
          state_d    = S_FLUSH;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else if (ph_vsync) begin
          // Frame start before the frame finished: restart in place
          err_d      = 1'b1;
          err_code_d = ERR_FRAME;
          word_cnt_d = '0;
          line_cnt_d = '0;
          in_line_d  = 1'b0;
          wrapped_d  = 1'b0;
          sof_seen_d = 1'b0;
        end else begin
          if (ph_valid) begin
            if (wrapped_q) begin
              line_err = 1'b1;
            end else begin
              pix_valid_d = 1'b1;
              pix_data_d  = ph_data;
              pix_sof_d   = !sof_seen_q;
              sof_seen_d  = 1'b1;
              in_line_d   = 1'b1;
              if (word_cnt_q == LAST_WORD) begin
                pix_eol_d  = 1'b1;
                word_cnt_d = '0;
                wrapped_d  = 1'b1;
                line_cnt_d = line_cnt_q + LINE_W'(1);
                frame_last = (line_cnt_q == LAST_LINE);
              end else begin
                word_cnt_d = word_cnt_q + WORD_W'(1);
              end
            end
          end
          // Packet end evaluated after any word in the same cycle
          if (ph_done) begin
            if (in_line_d && (word_cnt_d != '0)) begin
              line_err = 1'b1;
            end
            in_line_d = 1'b0;
            wrapped_d = 1'b0;
          end
          if (line_err) begin
            state_d     = S_FLUSH;
            err_d       = 1'b1;
            err_code_d  = ERR_LINE;
            pix_valid_d = 1'b0;
            pix_sof_d   = 1'b0;
            pix_eol_d   = 1'b0;
          end else if (frame_last) begin
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            state_d     = (single_q || stop_pend_q || cmd_stop) ? S_IDLE : S_ARM;
          end
        end
      end

      S_FLUSH: begin
        if (cmd_stop) begin
          stop_pend_d = 1'b1;
        end
        if (rst_cnt_q == RST_END) begin
          state_d = (single_q || stop_pend_q || cmd_stop) ? S_IDLE : S_ARM;
        end else begin
          ph_rst_n_d = 1'b0;
          rst_cnt_d  = rst_cnt_q + RST_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      in_line_q   <= 1'b0;
      wrapped_q   <= 1'b0;
      sof_seen_q  <= 1'b0;
      single_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      frame_cnt_q <= '0;
      rst_cnt_q   <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ph_rst_n_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      line_cnt_q  <= line_cnt_d;
      in_line_q   <= in_line_d;
      wrapped_q   <= wrapped_d;
      sof_seen_q  <= sof_seen_d;
      single_q    <= single_d;
      stop_pend_q <= stop_pend_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_sof_q   <= pix_sof_d;
      pix_eol_q   <= pix_eol_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ph_rst_n_q  <= ph_rst_n_d;
      busy_q      <= busy_d;
    end
  end

  assign ph_rst_n   = ph_rst_n_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_sof    = pix_sof_q;
  assign pix_eol    = pix_eol_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/csi_capture_ctrl.md
# csi_capture_ctrl

Frame-capture controller that sits directly downstream of the CSI-2 packet handler and sequences it. It arms on a host command and waits for frame start. It then forwards line payload words with line and frame framing, checks line length and line count, and recovers from stalls or malformed packets by pulsing the packet handler's reset. It is the single point where host capture control (start/stop/single-shot) meets the MIPI receive datapath.

## Interface
Parameters:
- H_WORDS, 640: expected 16-bit payload words per line (long packet length / 2).
- V_LINES, 480: expected long (line) packets per frame.
- TIMEOUT, 1_000_000: cycles without handler activity before a stall error.
- RST_CYCLES, 4: cycles ph_rst_n is held low during recovery.

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous active-high reset.
- cmd_start  in  1  pulse: arm capture.
- cmd_stop  in  1  pulse: stop after the current frame completes.
- single_shot  in  1  level, sampled on cmd_start: capture one frame then idle.
- ph_data  in  16  handler payload word.
- ph_valid  in  1  handler payload word valid.
- ph_vsync  in  1  handler frame-start strobe.
- ph_done  in  1  handler end-of-packet strobe (long and short packets).
- ph_rst_n  out  1  active-low reset to the packet handler.
- pix_data  out  16  forwarded payload word.
- pix_valid  out  1  pix_data valid.
- pix_sof  out  1  with the first pix_valid of a frame.
- pix_eol  out  1  with the last pix_valid of a line.
- frame_done  out  1  one-cycle pulse, frame complete.
- frame_err  out  1  one-cycle pulse, error detected.
- err_code  out  2  last error: 0 none, 1 timeout, 2 line length, 3 short frame; held until next error or cmd_start.
- busy  out  1  high in any state except IDLE.
- frame_cnt  out  16  completed frames since reset, wraps at 2^16.

## Operation
- States: IDLE, ARM, CAPTURE, FLUSH.
- IDLE: cmd_start -> ARM; latches single_shot, clears err_code and stop_pend.
- ARM: ph_vsync -> CAPTURE, clearing word_cnt, line_cnt, in_line and sof_pend. cmd_stop -> IDLE. Timeout -> FLUSH (err 1).
- CAPTURE, word forwarding: each ph_valid increments word_cnt and sets in_line. pix_sof marks the first forwarded word after FS.
- CAPTURE, line end: word_cnt == H_WORDS-1 gives pix_eol; line_cnt increments and word_cnt clears.
- CAPTURE, long line: a ph_valid while word_cnt has already wrapped for this line (in_line set, no ph_done yet) -> word dropped, FLUSH (err 2).
- CAPTURE, short line: ph_done with in_line set and word_cnt != 0 -> FLUSH (err 2).
- CAPTURE, packet end: ph_done clears in_line. ph_done without in_line (short packet) is ignored.
- CAPTURE, frame complete: line_cnt reaches V_LINES -> frame_done and frame_cnt+1. Next state is IDLE if single_shot or stop_pend, else ARM.
- CAPTURE, early frame start: ph_vsync before V_LINES lines -> frame_err (err 3). Counters reset and the controller stays in CAPTURE as a new frame; no flush.
- CAPTURE, stop request: cmd_stop sets stop_pend; the frame in progress still completes.
- CAPTURE, stall: timeout -> FLUSH (err 1).
- FLUSH: ph_rst_n low for RST_CYCLES. Then -> IDLE if stop_pend or single_shot, else ARM. cmd_stop in FLUSH sets stop_pend.
- Timeout counter: cleared by any ph_valid, ph_vsync or ph_done, and on every state change. Counts only in ARM and CAPTURE. Saturates; fires at TIMEOUT-1.
- Priority: sys_rst > error > frame complete > cmd_stop > cmd_start. cmd_start outside IDLE is ignored. cmd_start together with cmd_stop in IDLE stays in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - pix_* = 0, frame_done = frame_err = 0, err_code = 0, busy = 0, frame_cnt = 0.
  - ph_rst_n = 0 while sys_rst is high, 1 from the first cycle after.
- All outputs are registered.
- pix_data, pix_valid, pix_sof and pix_eol lag ph_* by exactly 1 cycle.
- frame_done coincides with the final pix_eol.
- frame_err asserts the cycle after the offending input; err_code updates in the same cycle.
- ph_rst_n goes low the cycle after entering FLUSH, for exactly RST_CYCLES cycles.
- An input ph_vsync in the same cycle as the ARM->CAPTURE transition is the FS that starts the frame.
- sys_rst mid-frame aborts immediately: no frame_done, no frame_err.

## Structure
- Package csi_ctrl_pkg holds:
  - State encoding: IDLE=0, ARM=1, CAPTURE=2, FLUSH=3.
  - Error codes: ERR_NONE, ERR_TIMEOUT, ERR_LINE, ERR_FRAME.
  - Counter width constants.
- Sub-module csi_wdt: a TIMEOUT watchdog with clear/enable/fire, reused later for other MIPI stall checks.
- The FSM, counters and output registers live in csi_capture_ctrl.

## Test plan
All scenarios use H_WORDS=4, V_LINES=3, TIMEOUT=64, RST_CYCLES=4.
- Nominal: cmd_start, FS, 3 lines × 4 words each followed by ph_done -> 12 pix_valid; pix_sof on word 0; pix_eol on words 3, 7, 11; frame_done with the last; frame_cnt=1; state returns to ARM.
- Single-shot and stop: cmd_start with single_shot=1 -> after one frame, busy=0. Separately, cmd_stop mid-frame -> frame completes, then IDLE.
- Short line: line of 3 words then ph_done -> frame_err, err_code=2, ph_rst_n low 4 cycles, then ARM.
- Long line: 5 words in one packet -> word 5 not forwarded, err_code=2, FLUSH.
- Early FS: FS after 2 lines -> frame_err, err_code=3; the next 3 lines complete with frame_done, no ph_rst_n pulse.
- Timeout and reset: ARM with no input for 64 cycles -> err_code=1, FLUSH. sys_rst mid-CAPTURE -> all outputs at reset values the next cycle.
